// File: rtl/mlo_axi_pkg.sv
// Shared AXI constants, FSM state types and the burst legality check
// for the MLO HBM responder.
package mlo_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic       {R_IDLE, R_BURST} rd_state_e;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wr_state_e;

  // FIXED is served as INCR; only full-width beats are supported
  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size,
                                    input int data_bits);
    return ((burst == BURST_INCR) || (burst == BURST_FIXED)) &&
           ((32'd8 << size) == 32'(data_bits));
  endfunction

endpackage

// File: rtl/mlo_ram_sdp.sv
// Simple-dual-port RAM: byte-enabled write port, 1-cycle read port,
// read-first on address collision.
module mlo_ram_sdp #(
  parameter int DATA_BITS = 256,
  parameter int WORDS     = 1024,
  localparam int IDX_BITS = $clog2(WORDS)
) (
  input  logic                   aclk,
  input  logic                   we,
  input  logic [IDX_BITS-1:0]    waddr,
  input  logic [DATA_BITS-1:0]   wdata,
  input  logic [DATA_BITS/8-1:0] be,
  input  logic                   re,
  input  logic [IDX_BITS-1:0]    raddr,
  output logic [DATA_BITS-1:0]   rdata
);

  logic [DATA_BITS-1:0] mem [WORDS];

  always_ff @(posedge aclk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DATA_BITS/8; b++)
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/mlo_hbm_responder.sv
// AXI4 slave memory responder: independent read/write FSMs over an SDP RAM,
// with a 2-entry R buffer so reads stream without bubbles.
module mlo_hbm_responder
  import mlo_axi_pkg::*;
#(
  parameter int ADDR_BITS = 64,
  parameter int DATA_BITS = 256,
  parameter int ID_BITS   = 2,
  parameter int MEM_WORDS = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDR_BITS-1:0]   s_axi_araddr,
  input  logic [1:0]             s_axi_arburst,
  input  logic [3:0]             s_axi_arcache,
  input  logic [ID_BITS-1:0]     s_axi_arid,
  input  logic [7:0]             s_axi_arlen,
  input  logic                   s_axi_arlock,
  input  logic [2:0]             s_axi_arprot,
  input  logic [2:0]             s_axi_arsize,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DATA_BITS-1:0]   s_axi_rdata,
  output logic [ID_BITS-1:0]     s_axi_rid,
  output logic                   s_axi_rlast,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  input  logic [ADDR_BITS-1:0]   s_axi_awaddr,
  input  logic [1:0]             s_axi_awburst,
  input  logic [3:0]             s_axi_awcache,
  input  logic [ID_BITS-1:0]     s_axi_awid,
  input  logic [7:0]             s_axi_awlen,
  input  logic                   s_axi_awlock,
  input  logic [2:0]             s_axi_awprot,
  input  logic [2:0]             s_axi_awsize,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_BITS-1:0]   s_axi_wdata,
  input  logic [DATA_BITS/8-1:0] s_axi_wstrb,
  input  logic                   s_axi_wlast,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [ID_BITS-1:0]     s_axi_bid,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready
);

  localparam int OFF_BITS = $clog2(DATA_BITS/8);
  localparam int IDX_BITS = $clog2(MEM_WORDS);
  localparam logic [IDX_BITS-1:0] IDX_ONE = 1;

  logic unused_ok;
  assign unused_ok = ^{s_axi_arcache, s_axi_arlock, s_axi_arprot, s_axi_araddr,
                       s_axi_awcache, s_axi_awlock, s_axi_awprot, s_axi_awaddr};

  logic                 ram_we, ram_re;
  logic [IDX_BITS-1:0]  ram_raddr;
  logic [DATA_BITS-1:0] ram_rdata;

  // ---------------- read path ----------------
  rd_state_e            r_state, r_state_nx;
  logic [IDX_BITS-1:0]  r_issue_idx;
  logic [7:0]           r_issue_left, r_push_cnt;
  logic                 r_err, r_inflight;
  logic [ID_BITS-1:0]   r_id_q;
  logic [DATA_BITS-1:0] buf_data [2];
  logic [1:0]           buf_last, buf_cnt;
  logic                 buf_wp, buf_rp;
  logic                 ar_hs, r_hs, issue_more;
  logic [2:0]           cnt_after;

  assign ar_hs     = s_axi_arvalid && (r_state == R_IDLE);
  assign r_hs      = s_axi_rvalid && s_axi_rready;
  assign cnt_after = {1'b0, buf_cnt} + {2'b0, r_inflight} - {2'b0, r_hs};
  // a read issued now lands two edges later, so keep one slot in reserve
  assign issue_more = (r_state == R_BURST) && (r_issue_left != 8'd0) && (cnt_after <= 3'd1);
  assign ram_re    = ar_hs || issue_more;
  assign ram_raddr = ar_hs ? s_axi_araddr[OFF_BITS +: IDX_BITS] : r_issue_idx;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    unique case (r_state)
      R_IDLE:  if (s_axi_arvalid) r_state_nx = R_BURST;
      R_BURST: if (r_hs && s_axi_rlast) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_issue_idx  <= '0;
      r_issue_left <= '0;
      r_push_cnt   <= '0;
      r_err        <= 1'b0;
      r_inflight   <= 1'b0;
      r_id_q       <= '0;
      buf_data[0]  <= '0;
      buf_data[1]  <= '0;
      buf_last     <= '0;
      buf_cnt      <= '0;
      buf_wp       <= 1'b0;
      buf_rp       <= 1'b0;
    end else begin
      r_inflight <= ram_re;
      if (ar_hs) begin
        r_id_q       <= s_axi_arid;
        r_err        <= !burst_ok(s_axi_arburst, s_axi_arsize, DATA_BITS);
        r_issue_idx  <= s_axi_araddr[OFF_BITS +: IDX_BITS] + IDX_ONE;
        r_issue_left <= s_axi_arlen;
        r_push_cnt   <= s_axi_arlen;
      end else if (issue_more) begin
        r_issue_idx  <= r_issue_idx + IDX_ONE;
        r_issue_left <= r_issue_left - 8'd1;
      end
      if (r_inflight) begin
        buf_data[buf_wp] <= r_err ? '0 : ram_rdata;
        buf_last[buf_wp] <= (r_push_cnt == 8'd0);
        buf_wp           <= ~buf_wp;
        r_push_cnt       <= r_push_cnt - 8'd1;
      end
      if (r_hs) buf_rp <= ~buf_rp;
      buf_cnt <= cnt_after[1:0];
    end
  end

  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rvalid  = (buf_cnt != 2'd0);
  assign s_axi_rdata   = buf_data[buf_rp];
  assign s_axi_rlast   = s_axi_rvalid && buf_last[buf_rp];
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = r_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------- write path ----------------
  wr_state_e           w_state, w_state_nx;
  logic [IDX_BITS-1:0] w_idx;
  logic [7:0]          w_cnt;
  logic                w_err, w_lerr, w_hs, w_final;
  logic [ID_BITS-1:0]  w_id_q;
  logic [1:0]          b_resp_q;

  assign w_hs    = s_axi_wvalid && (w_state == W_DATA);
  assign w_final = (w_cnt == 8'd0);
  assign ram_we  = w_hs && !w_err;

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_ADDR;
    else        w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    unique case (w_state)
      W_ADDR:  if (s_axi_awvalid) w_state_nx = W_DATA;
      W_DATA:  if (w_hs && w_final) w_state_nx = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_nx = W_ADDR;
      default: w_state_nx = W_ADDR;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_idx    <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
      w_lerr   <= 1'b0;
      w_id_q   <= '0;
      b_resp_q <= RESP_OKAY;
    end else begin
      if (w_state == W_ADDR && s_axi_awvalid) begin
        w_id_q <= s_axi_awid;
        w_idx  <= s_axi_awaddr[OFF_BITS +: IDX_BITS];
        w_cnt  <= s_axi_awlen;
        w_err  <= !burst_ok(s_axi_awburst, s_axi_awsize, DATA_BITS);
        w_lerr <= 1'b0;
      end
      if (w_hs) begin
        w_idx <= w_idx + IDX_ONE;
        w_cnt <= w_cnt - 8'd1;
        // awlen owns the burst length; wlast only flags a mismatch
        if (w_final) b_resp_q <= (w_err || w_lerr || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
        else if (s_axi_wlast) w_lerr <= 1'b1;
      end
    end
  end

  assign s_axi_awready = (w_state == W_ADDR);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = b_resp_q;

  mlo_ram_sdp #(.DATA_BITS(DATA_BITS), .WORDS(MEM_WORDS)) u_ram (
    .aclk  (aclk),
    .we    (ram_we),
    .waddr (w_idx),
    .wdata (s_axi_wdata),
    .be    (s_axi_wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mlo_hbm_responder.sv
// Scoreboard bench for mlo_hbm_responder: tasks push expected R/B responses
// from a word-array memory model; negedge monitors pop and compare.
module tb_mlo_hbm_responder;
  localparam int AW = 64, DW = 256, IW = 2, MW = 1024, SB = DW/8;

  logic aclk = 0, areset = 1;
  logic [AW-1:0] s_axi_araddr = '0, s_axi_awaddr = '0;
  logic [1:0] s_axi_arburst = 0, s_axi_awburst = 0;
  logic [3:0] s_axi_arcache = 0, s_axi_awcache = 0;
  logic [IW-1:0] s_axi_arid = 0, s_axi_awid = 0;
  logic [7:0] s_axi_arlen = 0, s_axi_awlen = 0;
  logic s_axi_arlock = 0, s_axi_awlock = 0;
  logic [2:0] s_axi_arprot = 0, s_axi_awprot = 0, s_axi_arsize = 0, s_axi_awsize = 0;
  logic s_axi_arvalid = 0, s_axi_awvalid = 0, s_axi_arready, s_axi_awready;
  logic [DW-1:0] s_axi_rdata, s_axi_wdata = '0;
  logic [IW-1:0] s_axi_rid, s_axi_bid;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready = 1;
  logic [1:0] s_axi_rresp, s_axi_bresp;
  logic [SB-1:0] s_axi_wstrb = '0;
  logic s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready = 1;

  mlo_hbm_responder #(.ADDR_BITS(AW), .DATA_BITS(DW), .ID_BITS(IW), .MEM_WORDS(MW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arlock(s_axi_arlock),
    .s_axi_arprot(s_axi_arprot), .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
    .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awlock(s_axi_awlock),
    .s_axi_awprot(s_axi_awprot), .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [DW-1:0] data; logic [IW-1:0] id; logic [1:0] resp; logic last; int cyc;} r_exp_t;
  typedef struct {logic [IW-1:0] id; logic [1:0] resp; int cyc;} b_exp_t;
  r_exp_t r_q[$];
  b_exp_t b_q[$];

  logic [DW-1:0] model [MW];
  logic [DW-1:0] wbuf_data [256];
  logic [SB-1:0] wbuf_strb [256];
  logic          wbuf_last [256];
  int checks = 0, errors = 0, cyc = 0, rmode = 0;

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int widx(input logic [AW-1:0] addr);
    return int'((addr >> $clog2(SB)) % MW);
  endfunction

  function automatic logic legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b00 || burst == 2'b01) && (SB == (1 << size));
  endfunction

  // Writes wbuf_* beats 0..len; model updated as each beat is accepted
  task automatic do_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [IW-1:0] id);
    int n, t_aw, w, mis;
    b_exp_t e;
    mis = 0;
    @(negedge aclk);
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awburst = burst;
    s_axi_awsize = size; s_axi_awid = id; s_axi_awvalid = 1;
    n = 0;
    while (!s_axi_awready && n < 200) begin @(negedge aclk); n++; end
    chk("aw_timeout", 32'(n < 200), 1);
    @(posedge aclk); #1 s_axi_awvalid = 0; t_aw = cyc;
    for (int k = 0; k <= len; k++) begin
      s_axi_wdata = wbuf_data[k]; s_axi_wstrb = wbuf_strb[k]; s_axi_wlast = wbuf_last[k];
      s_axi_wvalid = 1;
      @(negedge aclk);
      if (k == 0) chk("aw_w_ready_after_aw", {s_axi_awready, s_axi_wready}, 2'b01);
      n = 0;
      while (!s_axi_wready && n < 200) begin @(negedge aclk); n++; end
      if (n >= 200) begin chk("w_timeout", 32'(n), 0); break; end
      @(posedge aclk); #1;
      if (wbuf_last[k] != (k == len)) mis = 1;
      if (legal(burst, size)) begin
        w = (widx(addr) + k) % MW;
        for (int b = 0; b < SB; b++)
          if (wbuf_strb[k][b]) model[w][b*8 +: 8] = wbuf_data[k][b*8 +: 8];
      end
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    chk("w_full_rate", 32'(cyc - t_aw), 32'(len + 1));
    e.id = id; e.resp = (legal(burst, size) && mis == 0) ? 2'b00 : 2'b10; e.cyc = cyc;
    b_q.push_back(e);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [IW-1:0] id, input bit timed);
    int n, t;
    r_exp_t e;
    @(negedge aclk);
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arburst = burst;
    s_axi_arsize = size; s_axi_arid = id; s_axi_arvalid = 1;
    n = 0;
    while (!s_axi_arready && n < 600) begin @(negedge aclk); n++; end
    chk("ar_timeout", 32'(n < 600), 1);
    @(posedge aclk); #1 s_axi_arvalid = 0; t = cyc;
    for (int k = 0; k <= len; k++) begin
      e.data = legal(burst, size) ? model[(widx(addr) + k) % MW] : '0;
      e.id = id; e.resp = legal(burst, size) ? 2'b00 : 2'b10;
      e.last = (k == len); e.cyc = timed ? t + 1 + k : -1;
      r_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 2000) begin @(negedge aclk); n++; end
    if (n >= 2000) begin
      chk("drain_timeout", 32'(r_q.size() + b_q.size()), 0);
      r_q.delete(); b_q.delete();
    end
    @(negedge aclk);
  endtask

  task automatic fill_beats(input int len, input bit rnd, input logic [DW-1:0] base);
    for (int k = 0; k <= len; k++) begin
      wbuf_data[k] = rnd ? rnd256() : base + DW'(k);
      wbuf_strb[k] = '1; wbuf_last[k] = (k == len);
    end
  endtask

  // rready pattern generator
  initial begin
    int ph = 0;
    forever begin
      @(posedge aclk); #1;
      case (rmode)
        1: s_axi_rready = (ph % 3 == 0);
        2: s_axi_rready = 1'($urandom_range(0, 1));
        default: s_axi_rready = 1;
      endcase
      ph++;
    end
  end

  // R monitor: pops on every handshake, checks hold during stalls
  initial begin
    r_exp_t e;
    logic stall = 0;
    logic [DW-1:0] pd = '0;
    logic [5:0] pc = '0;
    forever begin
      @(negedge aclk);
      if (areset) stall = 0;
      else begin
        if (stall) begin
          chk("r_hold_data", s_axi_rdata, pd);
          chk("r_hold_ctl", {s_axi_rvalid, s_axi_rid, s_axi_rresp, s_axi_rlast}, pc);
        end
        if (s_axi_rvalid && s_axi_rready) begin
          if (r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_extra_beat: got unexpected beat %0h, expected none", s_axi_rdata);
          end else begin
            e = r_q.pop_front();
            chk("r_data", s_axi_rdata, e.data);
            chk("r_id_resp_last", {s_axi_rid, s_axi_rresp, s_axi_rlast}, {e.id, e.resp, e.last});
            if (e.cyc >= 0) chk("r_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        stall = s_axi_rvalid && !s_axi_rready;
        pd = s_axi_rdata;
        pc = {s_axi_rvalid, s_axi_rid, s_axi_rresp, s_axi_rlast};
      end
    end
  end

  // B monitor
  initial begin
    b_exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset && s_axi_bvalid && s_axi_bready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra: got unexpected response %0d, expected none", s_axi_bresp);
        end else begin
          e = b_q.pop_front();
          chk("b_id_resp", {s_axi_bid, s_axi_bresp}, {e.id, e.resp});
          chk("b_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    int len, bad;
    logic [1:0] bu;
    logic [2:0] sz;
    // reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ready", {s_axi_arready, s_axi_awready}, 2'b11);
    chk("rst_valid", {s_axi_rvalid, s_axi_wready, s_axi_bvalid, s_axi_rlast}, 4'b0000);
    chk("rst_ids_resps", {s_axi_rresp, s_axi_bresp, s_axi_rid, s_axi_bid}, '0);
    chk("rst_rdata", s_axi_rdata, '0);
    areset = 0;

    // W presented before AW must not be taken
    s_axi_wvalid = 1;
    repeat (2) begin @(negedge aclk); chk("w_before_aw", 32'(s_axi_wready), 0); end
    s_axi_wvalid = 0;

    // preload entire memory
    for (int b = 0; b < MW/256; b++) begin
      fill_beats(255, 1, '0);
      do_write(AW'(b * 256 * SB), 255, 2'b01, 3'd5, 2'(b));
    end
    drain();

    // write then read
    fill_beats(3, 0, DW'('hA0));
    do_write(64'h40, 3, 2'b01, 3'd5, 2'd1);
    drain();
    do_read(64'h40, 3, 2'b01, 3'd5, 2'd2, 1);
    drain();

    // byte enables on word 5
    wbuf_data[0] = '1; wbuf_strb[0] = '1; wbuf_last[0] = 1;
    do_write(AW'(5 * SB), 0, 2'b01, 3'd5, 2'd0);
    drain();
    wbuf_data[0] = '0; wbuf_strb[0] = SB'(32'h0000000F);
    do_write(AW'(5 * SB), 0, 2'b00, 3'd5, 2'd3);
    drain();
    do_read(AW'(5 * SB), 0, 2'b01, 3'd5, 2'd0, 1);
    drain();

    // backpressure across the top of memory
    rmode = 1;
    do_read(AW'((MW - 2) * SB), 3, 2'b01, 3'd5, 2'd1, 0);
    drain();
    rmode = 0;

    // illegal bursts
    do_read(64'h100, 1, 2'b10, 3'd5, 2'd3, 1);
    drain();
    wbuf_data[0] = rnd256(); wbuf_strb[0] = '1; wbuf_last[0] = 1;
    do_write(AW'(7 * SB), 0, 2'b01, 3'd3, 2'd2);
    drain();
    do_read(AW'(7 * SB), 0, 2'b01, 3'd5, 2'd2, 1);
    drain();

    // wlast early on beat index 1
    fill_beats(3, 1, '0);
    wbuf_last[1] = 1; wbuf_last[3] = 1;
    do_write(AW'(20 * SB), 3, 2'b01, 3'd5, 2'd1);
    drain();
    do_read(AW'(20 * SB), 3, 2'b01, 3'd5, 2'd1, 1);
    drain();

    // concurrent 16-beat read and write to disjoint ranges
    fill_beats(15, 1, '0);
    fork
      do_write(AW'(600 * SB), 15, 2'b01, 3'd5, 2'd2);
      do_read(AW'(100 * SB), 15, 2'b01, 3'd5, 2'd3, 1);
    join
    drain();
    do_read(AW'(600 * SB), 15, 2'b01, 3'd5, 2'd0, 1);
    drain();

    // randomized write/read pairs
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 15);
      a = AW'($urandom_range(0, MW - 1)) * SB + AW'($urandom_range(0, SB - 1));
      if ($urandom_range(0, 3) == 0) a[40] = 1'b1;
      case ($urandom_range(0, 9))
        0: bu = 2'b10;
        1: bu = 2'b11;
        default: bu = 2'($urandom_range(0, 1));
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'd5;
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      for (int k = 0; k <= len; k++) begin
        wbuf_data[k] = rnd256(); wbuf_strb[k] = SB'($urandom);
        wbuf_last[k] = (k == len) ^ (k == bad);
      end
      do_write(a, len, bu, sz, 2'($urandom));
      drain();
      rmode = 2;
      do_read(a, len, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01, 3'd5, 2'($urandom), 0);
      drain();
      rmode = 0;
    end

    // reset mid-read, then a fresh read
    do_read(AW'(300 * SB), 15, 2'b01, 3'd5, 2'd1, 1);
    repeat (5) @(posedge aclk);
    #1 areset = 1;
    r_q.delete();
    @(posedge aclk);
    #1 areset = 0;
    @(negedge aclk);
    chk("mid_reset_state", {s_axi_rvalid, s_axi_arready}, 2'b01);
    do_read(AW'(301 * SB), 3, 2'b01, 3'd5, 2'd2, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
